quad_encoder_counter: RTL and testbench



---
 rtl/quad_encoder_counter.sv | 173 +++++++++++++++++
 tb/tb_quad_encoder_counter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_encoder_counter.sv
// quad_encoder_counter
//
// Decodes the debounced A/B phases of one rotary encoder into up/down
// steps. It keeps a WIDTH-bit value register that feeds the downstream
// PWM/colour channel.
//
// Behaviour in brief:
// - Legal quadrature edges build up in a signed sub-step accumulator.
// - A full detent (EDGES_PER_STEP edges in one direction) counts one step.
// - A counted step moves the value by INCREMENT. The value either wraps
//   modulo 2^WIDTH or clamps at 0 and at 2^WIDTH-1.
// - Both phases changing in one sample is an illegal transition. It is
//   reported on error and discards any partial detent.
//
// Parameters:
//   WIDTH          width of the value register
//   INCREMENT      amount added/subtracted per step (1 .. 2^WIDTH-1)
//   EDGES_PER_STEP quadrature edges per counted step (1, 2 or 4)
//   SATURATE       0 = wrap, 1 = clamp at the limits
//   INIT_VALUE     value loaded on reset
//
// Ports:
//   clk    in   system clock
//   reset  in   synchronous, active-high reset
//   a, b   in   debounced encoder phases, synchronous to clk
//   value  out  current count (registered)
//   step   out  one-cycle pulse per counted step
//   dir    out  direction of the last step, 1 = up (valid while step = 1)
//   error  out  one-cycle pulse on an illegal transition
module quad_encoder_counter #(
    parameter int WIDTH          = 8,
    parameter int INCREMENT      = 1,
    parameter int EDGES_PER_STEP = 4,
    parameter int SATURATE       = 0,
    parameter int INIT_VALUE     = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a,
    input  logic             b,
    output logic [WIDTH-1:0] value,
    output logic             step,
    output logic             dir,
    output logic             error
);

    // Two spare bits give sign headroom beyond +/-(EDGES_PER_STEP-1).
    localparam int ACC_W = $clog2(EDGES_PER_STEP) + 2;

    localparam logic signed [ACC_W-1:0] ACC_ONE = ACC_W'(1);
    localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(EDGES_PER_STEP - 1);
    localparam logic signed [ACC_W-1:0] ACC_MIN = -ACC_MAX;

    localparam logic [WIDTH:0]   INC_EXT = (WIDTH + 1)'(INCREMENT);
    localparam logic [WIDTH-1:0] INIT_W  = WIDTH'(INIT_VALUE);
    localparam logic [WIDTH-1:0] MAX_W   = '1;

    // The extra carry/borrow bit in the WIDTH+1-bit sum flags a crossing
    // of the upper or lower limit.
    function automatic logic [WIDTH-1:0] step_up(input logic [WIDTH-1:0] v);
        logic [WIDTH:0] sum;
        sum = {1'b0, v} + INC_EXT;
        if ((SATURATE != 0) && sum[WIDTH]) begin
            step_up = MAX_W;
        end else begin
            step_up = sum[WIDTH-1:0];
        end
    endfunction

    function automatic logic [WIDTH-1:0] step_down(input logic [WIDTH-1:0] v);
        logic [WIDTH:0] diff;
        diff = {1'b0, v} - INC_EXT;
        if ((SATURATE != 0) && diff[WIDTH]) begin
            step_down = '0;
        end else begin
            step_down = diff[WIDTH-1:0];
        end
    endfunction

    logic [1:0]              cur;
    logic [1:0]              prev_ab_p1;
    logic signed [ACC_W-1:0] acc_p1;
    logic [WIDTH-1:0]        value_p1;
    logic                    step_p1;
    logic                    dir_p1;
    logic                    error_p1;

    logic                    fwd;
    logic                    rev;
    logic                    illegal;
    logic signed [ACC_W-1:0] acc_nxt;
    logic [WIDTH-1:0]        value_nxt;
    logic                    step_nxt;
    logic                    dir_nxt;
    logic                    error_nxt;

    assign cur = {a, b};

    // Stage 0: classify the {a,b} change against the previous sample.
    // Forward means A leads B. Idle (no change) falls through with all
    // flags clear.
    always_comb begin
        fwd     = 1'b0;
        rev     = 1'b0;
        illegal = 1'b0;
        case ({prev_ab_p1, cur})
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: fwd     = 1'b1;
            4'b10_00, 4'b11_10, 4'b01_11, 4'b00_01: rev     = 1'b1;
            4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: illegal = 1'b1;
            default: ;
        endcase
    end

    // A reversal mid-detent simply walks the accumulator back toward 0.
    // A step is counted only when an edge arrives with the accumulator
    // already at the full detent in that direction.
    always_comb begin
        acc_nxt   = acc_p1;
        value_nxt = value_p1;
        step_nxt  = 1'b0;
        dir_nxt   = dir_p1;
        error_nxt = 1'b0;
        if (fwd) begin
            if (acc_p1 == ACC_MAX) begin
                acc_nxt   = '0;
                step_nxt  = 1'b1;
                dir_nxt   = 1'b1;
                value_nxt = step_up(value_p1);
            end else begin
                acc_nxt = acc_p1 + ACC_ONE;
            end
        end else if (rev) begin
            if (acc_p1 == ACC_MIN) begin
                acc_nxt   = '0;
                step_nxt  = 1'b1;
                dir_nxt   = 1'b0;
                value_nxt = step_down(value_p1);
            end else begin
                acc_nxt = acc_p1 - ACC_ONE;
            end
        end else if (illegal) begin
            acc_nxt   = '0;
            error_nxt = 1'b1;
        end
    end

    // Stage 1: registered state and outputs.
    // On reset, prev_ab captures the live phase level so that it is never
    // mistaken for a transition once reset is released.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_ab_p1 <= cur;
            acc_p1     <= '0;
            value_p1   <= INIT_W;
            step_p1    <= 1'b0;
            dir_p1     <= 1'b0;
            error_p1   <= 1'b0;
        end else begin
            prev_ab_p1 <= cur;
            acc_p1     <= acc_nxt;
            value_p1   <= value_nxt;
            step_p1    <= step_nxt;
            dir_p1     <= dir_nxt;
            error_p1   <= error_nxt;
        end
    end

    assign value = value_p1;
    assign step  = step_p1;
    assign dir   = dir_p1;
    assign error = error_p1;

endmodule

// File: tb/tb_quad_encoder_counter.sv
// Testbench for quad_encoder_counter. Five differently parameterised
// instances share one a/b/reset stimulus. Every cycle, each instance is
// compared against a behavioural model in which quadrature phase is a Gray
// position 0..3 and value arithmetic is plain integer math. Directed table
// rows and hand-written sequences add constant expectations for the
// corner cases.
module tb_quad_encoder_counter;

    localparam int N = 5;
    localparam int P_INC  [N] = '{1, 16, 16, 5, 7};
    localparam int P_EPS  [N] = '{4, 4, 4, 2, 1};
    localparam int P_SAT  [N] = '{0, 1, 1, 0, 1};
    localparam int P_INIT [N] = '{0, 250, 3, 254, 0};

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       a     = 1'b1;
    logic       b     = 1'b1;
    logic [7:0] val [N];
    logic       stp [N];
    logic       dr  [N];
    logic       er  [N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        quad_encoder_counter #(
            .WIDTH         (8),
            .INCREMENT     (P_INC[g]),
            .EDGES_PER_STEP(P_EPS[g]),
            .SATURATE      (P_SAT[g]),
            .INIT_VALUE    (P_INIT[g])
        ) u_dut (
            .clk  (clk),
            .reset(reset),
            .a    (a),
            .b    (b),
            .value(val[g]),
            .step (stp[g]),
            .dir  (dr[g]),
            .error(er[g])
        );
    end

    int total  = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    logic [1:0] m_prev [N];
    int         m_acc  [N];
    int         m_val  [N];
    int         m_step [N];
    int         m_dir  [N];
    int         m_err  [N];

    // Position of a phase code on the quadrature cycle 00 -> 10 -> 11 -> 01.
    function automatic int gpos(input logic [1:0] x);
        case (x)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] gcode(input int p);
        logic [1:0] codes [4];
        codes = '{2'b00, 2'b10, 2'b11, 2'b01};
        return codes[p % 4];
    endfunction

    function automatic int mv_up(input int i, input int v);
        int s;
        s = v + P_INC[i];
        if (P_SAT[i] != 0) return (s > 255) ? 255 : s;
        return s % 256;
    endfunction

    function automatic int mv_dn(input int i, input int v);
        int s;
        s = v - P_INC[i];
        if (P_SAT[i] != 0) return (s < 0) ? 0 : s;
        return (s + 256) % 256;
    endfunction

    task automatic model_step(input logic r, input logic [1:0] ab);
        int d;
        for (int i = 0; i < N; i++) begin
            if (r) begin
                m_prev[i] = ab;
                m_acc[i]  = 0;
                m_val[i]  = P_INIT[i];
                m_step[i] = 0;
                m_dir[i]  = 0;
                m_err[i]  = 0;
            end else begin
                d = (gpos(ab) - gpos(m_prev[i]) + 4) % 4;
                m_step[i] = 0;
                m_err[i]  = 0;
                if (d == 1) begin
                    if (m_acc[i] == P_EPS[i] - 1) begin
                        m_acc[i] = 0; m_step[i] = 1; m_dir[i] = 1;
                        m_val[i] = mv_up(i, m_val[i]);
                    end else m_acc[i]++;
                end else if (d == 3) begin
                    if (m_acc[i] == -(P_EPS[i] - 1)) begin
                        m_acc[i] = 0; m_step[i] = 1; m_dir[i] = 0;
                        m_val[i] = mv_dn(i, m_val[i]);
                    end else m_acc[i]--;
                end else if (d == 2) begin
                    m_err[i] = 1;
                    m_acc[i] = 0;
                end
                m_prev[i] = ab;
            end
        end
    endtask

    // One clock: the DUT samples at posedge; compare #1 later.
    task automatic cycle();
        @(posedge clk);
        #1;
        model_step(reset, {a, b});
        for (int i = 0; i < N; i++) begin
            check($sformatf("model u%0d value", i), val[i], m_val[i]);
            check($sformatf("model u%0d step", i),  stp[i], m_step[i]);
            check($sformatf("model u%0d dir", i),   dr[i],  m_dir[i]);
            check($sformatf("model u%0d error", i), er[i],  m_err[i]);
        end
    endtask

    task automatic edge_fwd();
        {a, b} = gcode(gpos({a, b}) + 1);
        cycle();
    endtask

    task automatic edge_rev();
        {a, b} = gcode(gpos({a, b}) + 3);
        cycle();
    endtask

    // ---------------- directed table (checked on instance 0) ----------------
    typedef struct {
        logic       rst;
        logic [1:0] ab;
        int         reps;
        int         v;
        logic       s;
        logic       d;
        logic       e;
    } vec_t;

    vec_t tbl [$];

    task automatic add(input logic r, input logic [1:0] ab, input int reps,
                       input int v, input logic s, input logic d, input logic e);
        vec_t t;
        t.rst = r; t.ab = ab; t.reps = reps; t.v = v; t.s = s; t.d = d; t.e = e;
        tbl.push_back(t);
    endtask

    int nstep;

    initial begin
        // reset with a=b=1, then hold
        add(1, 2'b11, 1,  0, 0, 0, 0);
        add(0, 2'b11, 10, 0, 0, 0, 0);
        // restart at 00; forward detent, each level held 3 cycles
        add(1, 2'b00, 1, 0, 0, 0, 0);
        add(0, 2'b00, 3, 0, 0, 0, 0);
        add(0, 2'b10, 3, 0, 0, 0, 0);
        add(0, 2'b11, 3, 0, 0, 0, 0);
        add(0, 2'b01, 3, 0, 0, 0, 0);
        add(0, 2'b00, 1, 1, 1, 1, 0);
        add(0, 2'b00, 2, 1, 0, 1, 0);
        // reverse detent
        add(0, 2'b01, 3, 1, 0, 1, 0);
        add(0, 2'b11, 3, 1, 0, 1, 0);
        add(0, 2'b10, 3, 1, 0, 1, 0);
        add(0, 2'b00, 1, 0, 1, 0, 0);
        add(0, 2'b00, 2, 0, 0, 0, 0);
        // two forward, two back: unwinds, no step
        add(0, 2'b10, 1, 0, 0, 0, 0);
        add(0, 2'b11, 1, 0, 0, 0, 0);
        add(0, 2'b10, 1, 0, 0, 0, 0);
        add(0, 2'b00, 1, 0, 0, 0, 0);
        // full forward detent yields exactly one step
        add(0, 2'b10, 1, 0, 0, 0, 0);
        add(0, 2'b11, 1, 0, 0, 0, 0);
        add(0, 2'b01, 1, 0, 0, 0, 0);
        add(0, 2'b00, 1, 1, 1, 1, 0);
        // two down steps: 1 -> 0 -> 255 (wrap)
        add(0, 2'b01, 1, 1, 0, 1, 0);
        add(0, 2'b11, 1, 1, 0, 1, 0);
        add(0, 2'b10, 1, 1, 0, 1, 0);
        add(0, 2'b00, 1, 0, 1, 0, 0);
        add(0, 2'b01, 1, 0, 0, 0, 0);
        add(0, 2'b11, 1, 0, 0, 0, 0);
        add(0, 2'b10, 1, 0, 0, 0, 0);
        add(0, 2'b00, 1, 255, 1, 0, 0);
        // up step 255 -> 0 (wrap)
        add(0, 2'b10, 1, 255, 0, 0, 0);
        add(0, 2'b11, 1, 255, 0, 0, 0);
        add(0, 2'b01, 1, 255, 0, 0, 0);
        add(0, 2'b00, 1, 0, 1, 1, 0);
        // 00 -> 11 illegal jump, then four forward edges for one step
        add(0, 2'b11, 1, 0, 0, 1, 1);
        add(0, 2'b11, 1, 0, 0, 1, 0);
        add(0, 2'b01, 1, 0, 0, 1, 0);
        add(0, 2'b00, 1, 0, 0, 1, 0);
        add(0, 2'b10, 1, 0, 0, 1, 0);
        add(0, 2'b11, 1, 1, 1, 1, 0);

        foreach (tbl[r]) begin
            for (int k = 0; k < tbl[r].reps; k++) begin
                reset  = tbl[r].rst;
                {a, b} = tbl[r].ab;
                cycle();
                check($sformatf("tbl[%0d.%0d] value", r, k), val[0], tbl[r].v);
                check($sformatf("tbl[%0d.%0d] step", r, k),  stp[0], tbl[r].s);
                check($sformatf("tbl[%0d.%0d] dir", r, k),   dr[0],  tbl[r].d);
                check($sformatf("tbl[%0d.%0d] error", r, k), er[0],  tbl[r].e);
            end
        end

        // Back-to-back edges: 24 consecutive forward edges = 6 steps, 1 -> 7
        nstep = 0;
        repeat (24) begin
            edge_fwd();
            if (stp[0]) nstep++;
        end
        check("rate steps", nstep, 6);
        check("rate value", val[0], 7);

        // Reset after two edges of a detent discards the partial count
        edge_fwd();
        edge_fwd();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("midreset value", val[0], 0);
        check("midreset step", stp[0], 0);
        nstep = 0;
        repeat (2) begin
            edge_fwd();
            if (stp[0]) nstep++;
        end
        check("after reset no step", nstep, 0);
        check("after reset value", val[0], 0);
        repeat (2) begin
            edge_fwd();
            if (stp[0]) nstep++;
        end
        check("after reset full detent", nstep, 1);
        check("after reset value 1", val[0], 1);

        // Saturation: u1 starts at 250 (+/-16), u2 starts at 3 (+/-16)
        reset  = 1'b1;
        {a, b} = 2'b00;
        cycle();
        reset = 1'b0;
        check("sat u1 init", val[1], 250);
        check("sat u2 init", val[2], 3);
        repeat (4) edge_rev();
        check("sat u2 3-16 clamps", val[2], 0);
        check("sat u2 step", stp[2], 1);
        check("sat u2 dir", dr[2], 0);
        check("sat u1 down", val[1], 234);
        repeat (4) edge_rev();
        check("sat u2 holds 0", val[2], 0);
        check("sat u2 step at limit", stp[2], 1);
        repeat (12) edge_fwd();
        check("sat u1 250+16 clamps", val[1], 255);
        check("sat u1 step", stp[1], 1);
        check("sat u1 dir", dr[1], 1);
        repeat (4) edge_fwd();
        check("sat u1 holds 255", val[1], 255);
        check("sat u1 step at limit", stp[1], 1);

        // Randomized: idle / forward / reverse / illegal / occasional reset
        repeat (3000) begin
            int r;
            r = int'($urandom_range(0, 99));
            reset = (r < 2);
            r = int'($urandom_range(0, 99));
            if (r < 30)      {a, b} = {a, b};
            else if (r < 62) {a, b} = gcode(gpos({a, b}) + 1);
            else if (r < 94) {a, b} = gcode(gpos({a, b}) + 3);
            else             {a, b} = ~{a, b};
            cycle();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
